hdmi_timing_scheduler: RTL and testbench

Parametrised HDMI video timing generator and period scheduler that produces the pixel position, sync signals, and per-cycle TMDS period classification for the three `tmds_channel` encoders. Unlike the fixed-format generator, every timing value is a parameter, sync polarity is selectable, and data islands are scheduled on demand. A data island starts when an upstream packet source has a packet pending. It grows packet by packet while packets keep arriving, up to the number that fits in horizontal blanking. The block sits between the packet assembly logic (`data_island`) and the TMDS encode/serialise stage.

---
 rtl/hdmi_timing_scheduler.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_hdmi_timing_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_scheduler.sv
// hdmi_timing_scheduler
//
// Parametrised HDMI video timing generator and TMDS period scheduler. It walks
// the raster (cx, cy), produces the sync outputs and classifies each pixel
// period for the three TMDS channel encoders. Data islands are opened on
// demand in horizontal blanking when an upstream packet source has a packet
// pending, and grow slot by slot while packets keep arriving.
//
// Every period, sync and handshake output is registered from the current
// cx/cy, so it describes the position cx/cy showed one cycle earlier.
//
// Build option:
//   HDMI_TIMING_DATA_ISLAND_EN  defined   -> full HDMI behaviour (islands,
//                                            video preamble and video guard)
//                               undefined -> DVI output: no island FSM, no
//                                            preambles or guards, mode is 0/1
//
// Ports:
//   clk_pixel        in   pixel clock
//   reset            in   asynchronous, active-high reset
//   packet_valid     in   upstream has a packet pending
//   packet_ready     out  one-cycle pulse: packet consumed in this slot
//   packet_word      out  [4:0] offset 0..31 within the current packet
//   cx               out  [BIT_WIDTH:0] horizontal position
//   cy               out  [BIT_HEIGHT:0] vertical position
//   hsync, vsync     out  sync outputs, polarity set by SYNC_ACTIVE_HIGH
//   mode             out  [2:0] 0 control, 1 video, 2 video guard,
//                         3 data island, 4 island guard
//   video_preamble   out  CTL preamble before a video period
//   island_preamble  out  CTL preamble before a data island
//   frame_start      out  pulse for position (0,0)
module hdmi_timing_scheduler #(
    parameter int BIT_WIDTH        = 11,
    parameter int BIT_HEIGHT       = 10,
    parameter int FRAME_WIDTH      = 800,
    parameter int FRAME_HEIGHT     = 525,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480,
    parameter int HSYNC_START      = 16,
    parameter int HSYNC_WIDTH      = 96,
    parameter int VSYNC_START      = 0,
    parameter int VSYNC_WIDTH      = 2,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int ISLAND_START     = 4,
    parameter int MAX_PACKETS      = 18
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic                  packet_valid,
    output logic                  packet_ready,
    output logic [4:0]            packet_word,
    output logic [BIT_WIDTH:0]    cx,
    output logic [BIT_HEIGHT:0]   cy,
    output logic                  hsync,
    output logic                  vsync,
    output logic [2:0]            mode,
    output logic                  video_preamble,
    output logic                  island_preamble,
    output logic                  frame_start
);

    localparam int XW = BIT_WIDTH + 1;
    localparam int YW = BIT_HEIGHT + 1;
    localparam int SX = FRAME_WIDTH - SCREEN_WIDTH;
    localparam int SY = FRAME_HEIGHT - SCREEN_HEIGHT;

    // Island budget: preamble 8 + guard 2 + N*32 + guard 2 + holdoff 12 must
    // end by the video preamble at SX-10.
    localparam int NPK_FIT = (SX - 34 - ISLAND_START) / 32;
    localparam int NPK     = (MAX_PACKETS < NPK_FIT) ? MAX_PACKETS : NPK_FIT;

    localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
    localparam logic [XW-1:0] X_VIDEO  = XW'(SX);
    localparam logic [YW-1:0] Y_ACTIVE = YW'(SY);
    localparam logic [XW-1:0] X_HS_ON  = XW'(HSYNC_START);
    localparam logic [XW-1:0] X_HS_OFF = XW'(HSYNC_START + HSYNC_WIDTH);
    localparam logic [YW-1:0] Y_VS_ON  = YW'(VSYNC_START);
    localparam logic [YW-1:0] Y_VS_OFF = YW'(VSYNC_START + VSYNC_WIDTH);
    localparam logic          SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);

    localparam logic [2:0] MODE_CTRL  = 3'd0;
    localparam logic [2:0] MODE_VIDEO = 3'd1;

    if ((NPK < 1) || (ISLAND_START + 46 > SX - 10)) begin : g_bad_params
        $error("hdmi_timing_scheduler: horizontal blanking too short for a data island");
    end

    logic [XW-1:0] cx_next;
    logic [YW-1:0] cy_next;
    logic          hs_active;
    logic          vs_active;
    logic [2:0]    video_mode;
    logic          vpre_next;
    logic [2:0]    isl_mode_next;
    logic          ipre_next;
    logic          ready_next;
    logic [4:0]    word_next;
    logic [2:0]    mode_next;

    always_comb begin
        cx_next = cx + XW'(1);
        cy_next = cy;
        if (cx == X_LAST) begin
            cx_next = '0;
            cy_next = (cy == Y_LAST) ? '0 : cy + YW'(1);
        end
    end

    assign hs_active = (cx >= X_HS_ON) && (cx < X_HS_OFF);
    assign vs_active = (cy >= Y_VS_ON) && (cy < Y_VS_OFF);

`ifdef HDMI_TIMING_DATA_ISLAND_EN
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_DATA   = 3'd3;
    localparam logic [2:0] MODE_IGUARD = 3'd4;
    localparam logic [XW-1:0] X_VGUARD = XW'(SX - 2);
    localparam logic [XW-1:0] X_VPRE   = XW'(SX - 10);
    localparam logic [XW-1:0] X_ISLAND = XW'(ISLAND_START);
    localparam logic [7:0]    NPK_CNT  = 8'(NPK);

    always_comb begin
        video_mode = MODE_CTRL;
        vpre_next  = 1'b0;
        if (cy >= Y_ACTIVE) begin
            if (cx >= X_VIDEO) begin
                video_mode = MODE_VIDEO;
            end else if (cx >= X_VGUARD) begin
                video_mode = MODE_VGUARD;
            end else if (cx >= X_VPRE) begin
                vpre_next = 1'b1;
            end
        end
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LEAD_GUARD,
        S_PACKET,
        S_TRAIL_GUARD,
        S_HOLDOFF
    } island_state_t;

    // state/cnt describe the same position as the registered outputs; the
    // next-state values are decoded straight into the output registers.
    island_state_t state, state_next;
    logic [4:0]    cnt, cnt_next;
    logic [7:0]    sent, sent_next;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            sent  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sent  <= sent_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 5'd1;
        sent_next  = sent;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if ((cx == X_ISLAND) && packet_valid) begin
                    state_next = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (cnt == 5'd7) begin
                    state_next = S_LEAD_GUARD;
                    cnt_next   = '0;
                end
            end
            S_LEAD_GUARD: begin
                if (cnt == 5'd1) begin
                    state_next = S_PACKET;
                    cnt_next   = '0;
                    sent_next  = 8'd1;
                end
            end
            S_PACKET: begin
                // cnt is packet_word here; the slot decision is made while
                // the last word is on the outputs.
                if (cnt == 5'd31) begin
                    cnt_next = '0;
                    if (packet_valid && (sent < NPK_CNT)) begin
                        sent_next = sent + 8'd1;
                    end else begin
                        state_next = S_TRAIL_GUARD;
                    end
                end
            end
            S_TRAIL_GUARD: begin
                if (cnt == 5'd1) begin
                    state_next = S_HOLDOFF;
                    cnt_next   = '0;
                end
            end
            S_HOLDOFF: begin
                if (cnt == 5'd11) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        isl_mode_next = MODE_CTRL;
        ipre_next     = 1'b0;
        ready_next    = 1'b0;
        word_next     = '0;
        case (state_next)
            S_PREAMBLE:    ipre_next = 1'b1;
            S_LEAD_GUARD:  isl_mode_next = MODE_IGUARD;
            S_TRAIL_GUARD: isl_mode_next = MODE_IGUARD;
            S_PACKET: begin
                isl_mode_next = MODE_DATA;
                word_next     = cnt_next;
                ready_next    = (cnt_next == 5'd0);
            end
            default: ;
        endcase
    end
`else
    always_comb begin
        video_mode = MODE_CTRL;
        vpre_next  = 1'b0;
        if ((cy >= Y_ACTIVE) && (cx >= X_VIDEO)) begin
            video_mode = MODE_VIDEO;
        end
    end

    logic unused_packet_valid;
    assign unused_packet_valid = packet_valid;

    assign isl_mode_next = MODE_CTRL;
    assign ipre_next     = 1'b0;
    assign ready_next    = 1'b0;
    assign word_next     = '0;
`endif

    // Islands always finish before the video preamble, so the two period
    // sources never overlap; island classification takes priority.
    assign mode_next = (isl_mode_next != MODE_CTRL) ? isl_mode_next : video_mode;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cx              <= '0;
            cy              <= '0;
            hsync           <= ~SYNC_ON;
            vsync           <= ~SYNC_ON;
            mode            <= MODE_CTRL;
            video_preamble  <= 1'b0;
            island_preamble <= 1'b0;
            packet_ready    <= 1'b0;
            packet_word     <= '0;
            frame_start     <= 1'b0;
        end else begin
            cx              <= cx_next;
            cy              <= cy_next;
            hsync           <= hs_active ? SYNC_ON : ~SYNC_ON;
            vsync           <= vs_active ? SYNC_ON : ~SYNC_ON;
            mode            <= mode_next;
            video_preamble  <= vpre_next;
            island_preamble <= ipre_next;
            packet_ready    <= ready_next;
            packet_word     <= word_next;
            frame_start     <= (cx == '0) && (cy == '0);
        end
    end

endmodule

// File: tb/tb_hdmi_timing_scheduler.sv
module tb_hdmi_timing_scheduler;

    // A shortened frame keeps the run small; the horizontal blanking layout
    // (sx = 160, syncs, island start) matches the default 640x480 timing.
    localparam int FW   = 200;
    localparam int FH   = 30;
    localparam int SW   = 40;
    localparam int SH   = 20;
    localparam int SX   = FW - SW;
    localparam int SY   = FH - SH;
    localparam int HS0  = 16;
    localparam int HS1  = 16 + 96;
    localparam int VS0  = 0;
    localparam int VS1  = 2;
    localparam int IS   = 4;
    localparam int MAXP = 18;
    localparam int NPK  = (MAXP < (SX - 34 - IS) / 32) ? MAXP : (SX - 34 - IS) / 32;

`ifdef HDMI_TIMING_DATA_ISLAND_EN
    localparam bit ISL = 1'b1;
`else
    localparam bit ISL = 1'b0;
`endif

    // {cx, cy, hsync, vsync, mode, video_preamble, island_preamble,
    //  frame_start, packet_ready, packet_word}
    localparam logic [36:0] RST_V = {12'd0, 11'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        packet_valid = 1'b0;
    logic        packet_ready;
    logic [4:0]  packet_word;
    logic [11:0] cx;
    logic [10:0] cy;
    logic        hsync;
    logic        vsync;
    logic [2:0]  mode;
    logic        video_preamble;
    logic        island_preamble;
    logic        frame_start;

    hdmi_timing_scheduler #(
        .FRAME_WIDTH   (FW),
        .FRAME_HEIGHT  (FH),
        .SCREEN_WIDTH  (SW),
        .SCREEN_HEIGHT (SH)
    ) dut (
        .clk_pixel       (clk_pixel),
        .reset           (reset),
        .packet_valid    (packet_valid),
        .packet_ready    (packet_ready),
        .packet_word     (packet_word),
        .cx              (cx),
        .cy              (cy),
        .hsync           (hsync),
        .vsync           (vsync),
        .mode            (mode),
        .video_preamble  (video_preamble),
        .island_preamble (island_preamble),
        .frame_start     (frame_start)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0;
    int errors = 0;

    // Reference model state: position currently shown on cx/cy, and the
    // island in progress on this line (start position and slots granted).
    int mx, my;
    bit in_isl;
    int base, slots;
    int pending;
    int pdesc, ldesc;
    logic [36:0] exp_v;

    function automatic logic [36:0] obs_vec();
        return {cx, cy, hsync, vsync, mode, video_preamble, island_preamble,
                frame_start, packet_ready, packet_word};
    endfunction

    // Expected outputs after one clock edge, built from the raster rules and
    // the island schedule. packet_valid is the value seen at that edge.
    task automatic model_step(output logic [36:0] e);
        int p, l, off, r, md, pw, nx, ny;
        bit vp, ip, pr, hs, vs, fs;
        p = mx; l = my;
        md = 0; pw = 0; vp = 0; ip = 0; pr = 0;
        if (l >= SY) begin
            if (p >= SX) md = 1;
            else if (ISL && p >= SX - 2) md = 2;
            else if (ISL && p >= SX - 10) vp = 1;
        end
        if (ISL) begin
            if (!in_isl && p == IS && packet_valid) begin
                in_isl = 1; base = p; slots = 1;
            end
            if (in_isl) begin
                off = p - base;
                if (off < 8) ip = 1;
                else if (off < 10) md = 4;
                else begin
                    r = off - 10;
                    if (r == 32 * slots && slots < NPK && packet_valid) slots++;
                    if (r < 32 * slots) begin
                        md = 3; pw = r % 32; pr = (pw == 0);
                    end else if (r < 32 * slots + 2) begin
                        md = 4;
                    end else begin
                        in_isl = 0;
                    end
                end
            end
        end
        hs = (p >= HS0 && p < HS1) ? 1'b0 : 1'b1;
        vs = (l >= VS0 && l < VS1) ? 1'b0 : 1'b1;
        fs = (p == 0 && l == 0);
        nx = (p == FW - 1) ? 0 : p + 1;
        ny = (p == FW - 1) ? ((l == FH - 1) ? 0 : l + 1) : l;
        mx = nx; my = ny;
        e = {nx[11:0], ny[10:0], hs, vs, md[2:0], vp, ip, fs, pr, pw[4:0]};
    endtask

    // Packet source: holds valid while packets are pending, consumes one per
    // observed packet_ready and drops valid in that same cycle if empty.
    task automatic source_update();
        if (packet_ready && pending > 0) pending--;
        packet_valid = (pending > 0);
    endtask

    task automatic test_reset();
        pending = 0;
        packet_valid = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk_pixel); #1;
            checks++;
            if (obs_vec() !== RST_V) begin
                errors++;
                $display("FAIL reset_state got %h want %h", obs_vec(), RST_V);
            end
        end
        #2 reset = 1'b0;
        mx = 0; my = 0; in_isl = 0;
    endtask

    task automatic test_free_run();
        int fs_cnt = 0, hs_lo = 0, vs_lo = 0, max_mode = 0;
        for (int i = 0; i < FW * FH; i++) begin
            @(posedge clk_pixel); #1;
            pdesc = mx; ldesc = my;
            model_step(exp_v);
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL free_run pos %0d,%0d got %h want %h", pdesc, ldesc, obs_vec(), exp_v);
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (hsync === 1'b0) hs_lo++;
            if (vsync === 1'b0) vs_lo++;
            if (int'(mode) > max_mode) max_mode = int'(mode);
            source_update();
        end
        checks++;
        if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count got %0d want 1", fs_cnt); end
        checks++;
        if (hs_lo != 96 * FH) begin errors++; $display("FAIL hsync_low_count got %0d want %0d", hs_lo, 96 * FH); end
        checks++;
        if (vs_lo != 2 * FW) begin errors++; $display("FAIL vsync_low_count got %0d want %0d", vs_lo, 2 * FW); end
        checks++;
        if (max_mode != (ISL ? 2 : 1)) begin
            errors++; $display("FAIL max_mode_no_islands got %0d want %0d", max_mode, ISL ? 2 : 1);
        end
    endtask

    task automatic test_held_high();
        int rq[$];
        int exq[$];
        if (ISL) for (int k = 0; k < 2; k++) begin exq.push_back(14); exq.push_back(46); exq.push_back(78); end
        pending = 100000;
        packet_valid = 1'b1;
        for (int i = 0; i < 2 * FW; i++) begin
            @(posedge clk_pixel); #1;
            pdesc = mx; ldesc = my;
            model_step(exp_v);
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL held_high pos %0d,%0d got %h want %h", pdesc, ldesc, obs_vec(), exp_v);
            end
            if (packet_ready === 1'b1) rq.push_back(pdesc);
            source_update();
        end
        checks++;
        if (rq.size() != exq.size()) begin
            errors++; $display("FAIL held_high_ready_count got %0d want %0d", rq.size(), exq.size());
        end
        for (int k = 0; k < rq.size() && k < exq.size(); k++) begin
            checks++;
            if (rq[k] != exq[k]) begin
                errors++; $display("FAIL held_high_ready_pos[%0d] got %0d want %0d", k, rq[k], exq[k]);
            end
        end
    endtask

    task automatic test_single_packet();
        int nready = 0, last_g4 = -1;
        pending = 1;
        packet_valid = 1'b1;
        for (int i = 0; i < FW; i++) begin
            @(posedge clk_pixel); #1;
            pdesc = mx; ldesc = my;
            model_step(exp_v);
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL single_packet pos %0d,%0d got %h want %h", pdesc, ldesc, obs_vec(), exp_v);
            end
            if (packet_ready === 1'b1) nready++;
            if (mode === 3'd4) last_g4 = pdesc;
            source_update();
        end
        checks++;
        if (nready != (ISL ? 1 : 0)) begin
            errors++; $display("FAIL single_ready_count got %0d want %0d", nready, ISL ? 1 : 0);
        end
        checks++;
        if (last_g4 != (ISL ? 47 : -1)) begin
            errors++; $display("FAIL single_trail_guard_end got %0d want %0d", last_g4, ISL ? 47 : -1);
        end
    endtask

    task automatic test_mid_line_valid();
        int first_line_ready = 0, nready = 0;
        pending = 0;
        packet_valid = 1'b0;
        for (int i = 0; i < 2 * FW; i++) begin
            if (i == 60) begin pending = 2; packet_valid = 1'b1; end
            @(posedge clk_pixel); #1;
            pdesc = mx; ldesc = my;
            model_step(exp_v);
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL mid_line_valid pos %0d,%0d got %h want %h", pdesc, ldesc, obs_vec(), exp_v);
            end
            if (packet_ready === 1'b1) begin
                nready++;
                if (i < FW) first_line_ready++;
            end
            source_update();
        end
        checks++;
        if (first_line_ready != 0) begin
            errors++; $display("FAIL mid_line_ready_same_line got %0d want 0", first_line_ready);
        end
        checks++;
        if (nready != (ISL ? 2 : 0)) begin
            errors++; $display("FAIL mid_line_ready_count got %0d want %0d", nready, ISL ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid_island();
        int first_pos = -1, first_line = -1, guard = 0;
        pending = 3;
        packet_valid = 1'b1;
        while (mx != 30 && guard < 2 * FW) begin
            guard++;
            @(posedge clk_pixel); #1;
            pdesc = mx; ldesc = my;
            model_step(exp_v);
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL pre_reset pos %0d,%0d got %h want %h", pdesc, ldesc, obs_vec(), exp_v);
            end
            source_update();
        end
        checks++;
        if (mx != 30) begin errors++; $display("FAIL reach_pos30 got %0d want 30", mx); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== RST_V) begin
            errors++; $display("FAIL reset_async got %h want %h", obs_vec(), RST_V);
        end
        repeat (4) begin
            @(posedge clk_pixel); #1;
            checks++;
            if (obs_vec() !== RST_V) begin
                errors++; $display("FAIL reset_hold got %h want %h", obs_vec(), RST_V);
            end
        end
        #2 reset = 1'b0;
        mx = 0; my = 0; in_isl = 0;
        for (int i = 0; i < 2 * FW; i++) begin
            @(posedge clk_pixel); #1;
            pdesc = mx; ldesc = my;
            model_step(exp_v);
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL post_reset pos %0d,%0d got %h want %h", pdesc, ldesc, obs_vec(), exp_v);
            end
            if (packet_ready === 1'b1 && first_pos < 0) begin first_pos = pdesc; first_line = ldesc; end
            source_update();
        end
        checks++;
        if (first_pos != (ISL ? 14 : -1) || first_line != (ISL ? 0 : -1)) begin
            errors++;
            $display("FAIL post_reset_first_ready got %0d,%0d want %0d,%0d",
                     first_pos, first_line, ISL ? 14 : -1, ISL ? 0 : -1);
        end
    endtask

    task automatic test_back_to_back();
        bit prev_ready = 0;
        for (int i = 0; i < 20 * FW; i++) begin
            if (mx == 0) pending += $urandom_range(0, 3);
            else if ($urandom_range(0, 299) == 0) pending++;
            packet_valid = (pending > 0);
            @(posedge clk_pixel); #1;
            pdesc = mx; ldesc = my;
            model_step(exp_v);
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL back_to_back pos %0d,%0d got %h want %h", pdesc, ldesc, obs_vec(), exp_v);
            end
            if (packet_ready === 1'b1) begin
                checks++;
                if (prev_ready) begin
                    errors++; $display("FAIL ready_consecutive pos %0d got 1 want 0", pdesc);
                end
            end
            prev_ready = (packet_ready === 1'b1);
            source_update();
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_held_high();
        test_single_packet();
        test_mid_line_valid();
        test_reset_mid_island();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
